// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: binarises an activation vector into a mask, sums the
// masked weights of every output node over an Avalon-MM master, and writes clamped results.
module fc_layer_engine #(
    parameter int          N_IN      = 784,
    parameter int          N_OUT     = 200,
    parameter int          DW        = 16,
    parameter int          ACC_W     = 32,
    parameter logic [31:0] IN_BASE   = 32'd600000,
    parameter logic [31:0] W_BASE    = 32'd800,
    parameter logic [31:0] OUT_BASE  = 32'd400000,
    parameter bit          SKIP_ZERO = 1'b1,
    parameter bit          RELU      = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            waitrequest,
    input  logic            readdatavalid,
    input  logic [DW-1:0]   readdata,
    output logic            chipselect,
    output logic [DW/8-1:0] byteenable,
    output logic            read_n,
    output logic            write_n,
    output logic [31:0]     address,
    output logic [DW-1:0]   writedata,
    input  logic            start,
    output logic            done,
    output logic            busy,
    output logic [31:0]     status
);

    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [31:0]    STEP      = 32'(DW / 8);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(N_IN - 1);
    localparam logic [NW-1:0]  LAST_NODE = NW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IN_RD  = 4'd1,
        S_IN_WT  = 4'd2,
        S_W_CHK  = 4'd3,
        S_W_RD   = 4'd4,
        S_W_WT   = 4'd5,
        S_W_ADV  = 4'd6,
        S_OUT_WR = 4'd7,
        S_NXT    = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t                    state_q;
    logic                      read_n_q;
    logic                      write_n_q;
    logic [31:0]               addr_q;
    logic [DW-1:0]             wdata_q;
    logic                      done_q;
    logic                      busy_q;
    logic [IW-1:0]             idx_q;
    logic [NW-1:0]             node_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [N_IN-1:0]           mask_q;
    logic [31:0]               w_addr_q;
    logic [31:0]               out_addr_q;

    logic signed [ACC_W-1:0]   rd_ext;
    logic signed [ACC_W-1:0]   relu_val;
    logic [DW-1:0]             sat_word;

    assign rd_ext = {{(ACC_W-DW){readdata[DW-1]}}, readdata};

    always_comb begin
        relu_val = acc_q;
        if (RELU && acc_q[ACC_W-1]) begin
            relu_val = '0;
        end
        if (relu_val > SAT_MAX) begin
            sat_word = SAT_MAX[DW-1:0];
        end else if (relu_val < SAT_MIN) begin
            sat_word = SAT_MIN[DW-1:0];
        end else begin
            sat_word = relu_val[DW-1:0];
        end
    end

    // Weight address advances on every index, skipped or not, so rows stay aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            read_n_q   <= 1'b1;
            write_n_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            node_q     <= '0;
            acc_q      <= '0;
            mask_q     <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_IN_RD;
                        busy_q     <= 1'b1;
                        read_n_q   <= 1'b0;
                        addr_q     <= IN_BASE;
                        idx_q      <= '0;
                        node_q     <= '0;
                        acc_q      <= '0;
                        w_addr_q   <= W_BASE;
                        out_addr_q <= OUT_BASE;
                    end
                end
                S_IN_RD: begin
                    if (!waitrequest) begin
                        read_n_q <= 1'b1;
                        state_q  <= S_IN_WT;
                    end
                end
                S_IN_WT: begin
                    if (readdatavalid) begin
                        mask_q[idx_q] <= |readdata;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_W_CHK;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            addr_q   <= addr_q + STEP;
                            read_n_q <= 1'b0;
                            state_q  <= S_IN_RD;
                        end
                    end
                end
                S_W_CHK: begin
                    if (SKIP_ZERO && !mask_q[idx_q]) begin
                        state_q <= S_W_ADV;
                    end else begin
                        read_n_q <= 1'b0;
                        addr_q   <= w_addr_q;
                        state_q  <= S_W_RD;
                    end
                end
                S_W_RD: begin
                    if (!waitrequest) begin
                        read_n_q <= 1'b1;
                        state_q  <= S_W_WT;
                    end
                end
                S_W_WT: begin
                    if (readdatavalid) begin
                        // With SKIP_ZERO=0 every weight is fetched but only masked ones count.
                        if (mask_q[idx_q]) begin
                            acc_q <= acc_q + rd_ext;
                        end
                        state_q <= S_W_ADV;
                    end
                end
                S_W_ADV: begin
                    w_addr_q <= w_addr_q + STEP;
                    if (idx_q == LAST_IDX) begin
                        write_n_q <= 1'b0;
                        addr_q    <= out_addr_q;
                        wdata_q   <= sat_word;
                        state_q   <= S_OUT_WR;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_W_CHK;
                    end
                end
                S_OUT_WR: begin
                    if (!waitrequest) begin
                        write_n_q <= 1'b1;
                        state_q   <= S_NXT;
                    end
                end
                S_NXT: begin
                    acc_q      <= '0;
                    idx_q      <= '0;
                    out_addr_q <= out_addr_q + STEP;
                    if (node_q == LAST_NODE) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        node_q  <= node_q + 1'b1;
                        state_q <= S_W_CHK;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign chipselect = 1'b1;
    assign byteenable = '1;
    assign read_n     = read_n_q;
    assign write_n    = write_n_q;
    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign status     = {16'(node_q), 8'(idx_q), 8'(state_q)};

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: three instances (SKIP/RELU variants) share one memory slave.
module tb_fc_layer_engine;

    logic        clk;
    logic        reset_n;
    logic        waitrequest;
    logic        rdv;
    logic [15:0] rdata;
    logic [2:0]  start_vec;
    logic [1:0]  sel;

    logic        cs_v      [3];
    logic [1:0]  be_v      [3];
    logic        read_n_v  [3];
    logic        write_n_v [3];
    logic [31:0] addr_v    [3];
    logic [15:0] wdata_v   [3];
    logic        done_v    [3];
    logic        busy_v    [3];
    logic [31:0] status_v  [3];

    // Instance 0: SKIP=1 RELU=0, instance 1: SKIP=1 RELU=1, instance 2: SKIP=0 RELU=0
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        fc_layer_engine #(
            .N_IN(4), .N_OUT(2), .DW(16), .ACC_W(32),
            .IN_BASE(32'd600000), .W_BASE(32'd800), .OUT_BASE(32'd400000),
            .SKIP_ZERO((gi == 2) ? 1'b0 : 1'b1),
            .RELU((gi == 1) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest),
            .readdatavalid(rdv), .readdata(rdata),
            .chipselect(cs_v[gi]), .byteenable(be_v[gi]),
            .read_n(read_n_v[gi]), .write_n(write_n_v[gi]),
            .address(addr_v[gi]), .writedata(wdata_v[gi]),
            .start(start_vec[gi]), .done(done_v[gi]), .busy(busy_v[gi]),
            .status(status_v[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_read_n, m_write_n;
    logic [31:0] m_addr;
    logic [15:0] m_wdata;
    always_comb begin
        m_read_n  = read_n_v[sel];
        m_write_n = write_n_v[sel];
        m_addr    = addr_v[sel];
        m_wdata   = wdata_v[sel];
    end

    logic [15:0] mem [int];
    int          wait_cycles;
    int          wcnt;
    int          n_reads, n_writes, stab_err, hold_cnt;
    logic [31:0] rlog   [256];
    logic [31:0] wlog_a [256];
    logic [15:0] wlog_d [256];

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'h0000;
    endfunction

    assign waitrequest = (!m_read_n || !m_write_n) && (wcnt < wait_cycles);

    initial begin
        wcnt = 0; n_reads = 0; n_writes = 0; rdv = 1'b0; rdata = '0;
    end

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (!m_read_n || !m_write_n) begin
            if (waitrequest) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (!m_read_n) begin
                    rdv   <= 1'b1;
                    rdata <= mem_rd(m_addr);
                    rlog[n_reads[7:0]] <= m_addr;
                    n_reads <= n_reads + 1;
                end else begin
                    wlog_a[n_writes[7:0]] <= m_addr;
                    wlog_d[n_writes[7:0]] <= m_wdata;
                    n_writes <= n_writes + 1;
                end
            end
        end
    end

    // Bus outputs must not move while the slave stalls.
    logic        p_hold, p_rn, p_wn;
    logic [31:0] p_a;
    logic [15:0] p_wd;
    initial begin
        p_hold = 1'b0; stab_err = 0; hold_cnt = 0;
    end
    always @(negedge clk) begin
        if (p_hold && (m_read_n !== p_rn || m_write_n !== p_wn || m_addr !== p_a || m_wdata !== p_wd))
            stab_err <= stab_err + 1;
        if (waitrequest) hold_cnt <= hold_cnt + 1;
        p_hold <= waitrequest;
        p_rn   <= m_read_n;
        p_wn   <= m_write_n;
        p_a    <= m_addr;
        p_wd   <= m_wdata;
    end

    int n_cmp, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int               inst;
        int               waits;
        logic [3:0][15:0] in_v;
        logic [3:0][15:0] w0;
        logic [3:0][15:0] w1;
        logic [15:0]      exp0;
        logic [15:0]      exp1;
        int               exp_rd;
        bit               chk_waddr;
    } vec_t;

    function automatic logic [3:0][15:0] p4(input logic [15:0] a, b, c, d);
        logic [3:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic load(input logic [3:0][15:0] iv, w0, w1);
        mem.delete();
        for (int i = 0; i < 4; i++) begin
            mem[600000 + 2*i] = iv[i];
            mem[800 + 2*i]    = w0[i];
            mem[808 + 2*i]    = w1[i];
        end
    endtask

    task automatic run_inst(input logic [1:0] inst);
        int k;
        sel = inst;
        start_vec[inst] = 1'b1;
        k = 0;
        while (!done_v[inst] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("run_done", {31'd0, done_v[inst]}, 32'd1);
        chk("busy_in_done", {31'd0, busy_v[inst]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("done_held_with_start", {31'd0, done_v[inst]}, 32'd1);
        start_vec[inst] = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_dropped", {31'd0, done_v[inst]}, 32'd0);
        chk("back_to_idle", {24'd0, status_v[inst][7:0]}, 32'd0);
    endtask

    task automatic check_results(input string tag, input int rb, input int wb,
                                 input int exp_rd, input logic [15:0] e0, input logic [15:0] e1);
        chk({tag, "_reads"},  32'(n_reads - rb), 32'(exp_rd));
        chk({tag, "_writes"}, 32'(n_writes - wb), 32'd2);
        chk({tag, "_wa0"}, wlog_a[wb & 255], 32'd400000);
        chk({tag, "_wd0"}, {16'd0, wlog_d[wb & 255]}, {16'd0, e0});
        chk({tag, "_wa1"}, wlog_a[(wb + 1) & 255], 32'd400002);
        chk({tag, "_wd1"}, {16'd0, wlog_d[(wb + 1) & 255]}, {16'd0, e1});
    endtask

    vec_t vecs[5];
    int   rb, wb, sb, hb, k;

    initial begin
        n_cmp = 0; n_err = 0;
        sel = 2'd0; start_vec = 3'b000; wait_cycles = 0; reset_n = 1'b0;

        vecs[0] = '{0, 0, p4(16'd5, 16'd0, 16'd1, 16'd0),
                    p4(16'd3, 16'd100, 16'hFFFE, 16'd7), p4(16'hFFF6, 16'd1, 16'hFFFB, 16'd1),
                    16'h0001, 16'hFFF1, 8, 1'b0};
        vecs[1] = '{1, 0, p4(16'd5, 16'd0, 16'd1, 16'd0),
                    p4(16'd3, 16'd100, 16'hFFFE, 16'd7), p4(16'hFFF6, 16'd1, 16'hFFFB, 16'd1),
                    16'h0001, 16'h0000, 8, 1'b0};
        vecs[2] = '{2, 0, p4(16'd5, 16'd0, 16'd1, 16'd0),
                    p4(16'd3, 16'd100, 16'hFFFE, 16'd7), p4(16'hFFF6, 16'd1, 16'hFFFB, 16'd1),
                    16'h0001, 16'hFFF1, 12, 1'b1};
        vecs[3] = '{0, 0, p4(16'd1, 16'd1, 16'd1, 16'd1),
                    p4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), p4(16'h8000, 16'h8000, 16'h8000, 16'h8000),
                    16'h7FFF, 16'h8000, 12, 1'b0};
        vecs[4] = '{0, 3, p4(16'd5, 16'd0, 16'd1, 16'd0),
                    p4(16'd3, 16'd100, 16'hFFFE, 16'd7), p4(16'hFFF6, 16'd1, 16'hFFFB, 16'd1),
                    16'h0001, 16'hFFF1, 8, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_read_n",  {31'd0, read_n_v[0]},  32'd1);
        chk("rst_write_n", {31'd0, write_n_v[0]}, 32'd1);
        chk("rst_address", addr_v[0], 32'd0);
        chk("rst_wdata",   {16'd0, wdata_v[0]}, 32'd0);
        chk("rst_done",    {31'd0, done_v[0]}, 32'd0);
        chk("rst_busy",    {31'd0, busy_v[0]}, 32'd0);
        chk("rst_status",  status_v[0], 32'd0);
        chk("chipselect",  {31'd0, cs_v[0]}, 32'd1);
        chk("byteenable",  {30'd0, be_v[0]}, 32'd3);
        reset_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            load(vecs[t].in_v, vecs[t].w0, vecs[t].w1);
            wait_cycles = vecs[t].waits;
            @(negedge clk);
            rb = n_reads; wb = n_writes; sb = stab_err; hb = hold_cnt;
            run_inst(2'(vecs[t].inst));
            check_results($sformatf("vec%0d", t), rb, wb, vecs[t].exp_rd, vecs[t].exp0, vecs[t].exp1);
            chk("bus_stable", 32'(stab_err - sb), 32'd0);
            chk("stall_cycles", 32'(hold_cnt - hb), 32'(vecs[t].waits * (vecs[t].exp_rd + 2)));
            if (vecs[t].chk_waddr) begin
                for (int j = 0; j < 8; j++)
                    chk($sformatf("waddr%0d", j), rlog[(rb + 4 + j) & 255], 32'(800 + 2*j));
            end
            $display("vec %0d inst=%0d waits=%0d: reads=%0d writes=%0d out=%04h,%04h",
                     t, vecs[t].inst, vecs[t].waits, n_reads - rb, n_writes - wb,
                     wlog_d[wb & 255], wlog_d[(wb + 1) & 255]);
        end

        // Mid-run reset during the first weight read of node 1.
        load(vecs[0].in_v, vecs[0].w0, vecs[0].w1);
        wait_cycles = 0;
        sel = 2'd0;
        start_vec[0] = 1'b1;
        k = 0;
        while (!(addr_v[0] == 32'd808 && read_n_v[0] == 1'b0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reached_node1_read", addr_v[0], 32'd808);
        reset_n = 1'b0;
        start_vec[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_read_n",  {31'd0, read_n_v[0]},  32'd1);
        chk("midrst_write_n", {31'd0, write_n_v[0]}, 32'd1);
        chk("midrst_state",   status_v[0], 32'd0);
        chk("midrst_busy",    {31'd0, busy_v[0]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_done_low", {31'd0, done_v[0]}, 32'd0);
        chk("midrst_stay_idle", {31'd0, busy_v[0]}, 32'd0);
        rb = n_reads; wb = n_writes;
        run_inst(2'd0);
        check_results("restart", rb, wb, 8, 16'h0001, 16'hFFF1);
        $display("restart after reset: reads=%0d writes=%0d out=%04h,%04h",
                 n_reads - rb, n_writes - wb, wlog_d[wb & 255], wlog_d[(wb + 1) & 255]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
